mul_div_unit: RTL and testbench



---
 rtl/mul_div_if.sv | 25 ++
 rtl/mul_div_unit.sv | 141 ++++++++++++++
 tb/tb_mul_div_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Start/busy/done handshake and hi/lo result bus between pipeline control and mul_div_unit.
interface mul_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline control side
    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    // Multiply/divide unit side
    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Sequential 32-iteration multiply (shift-add) / divide (restoring) unit.
// Works on operand magnitudes and fixes the signs in a single cycle at the end,
// so every op and operand takes the same number of cycles.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    mul_div_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_is_div;
    logic             r_res_neg;
    logic             r_rem_neg;
    // r_x: multiplier (shifts right) or dividend (shifts left)
    // r_y: multiplicand or divisor
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_mul_add;
    logic [WIDTH:0]   w_mul_sum;
    logic [AW-1:0]    w_mul_next;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [AW-1:0]    w_div_next;
    logic [AW-1:0]    w_prod_neg;
    logic [WIDTH-1:0] w_quot_neg;
    logic [WIDTH-1:0] w_rem_neg;

    // Operand magnitudes; unsigned ops pass operands through untouched
    assign w_signed = bus.op[0];
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
    assign w_b_mag  = w_b_neg ? (~bus.b + WIDTH'(1)) : bus.b;

    // Shift-add step: add multiplicand to upper half keeping the carry, then shift right
    assign w_mul_add  = r_x[0] ? r_y : '0;
    assign w_mul_sum  = {1'b0, r_acc[AW-1:WIDTH]} + {1'b0, w_mul_add};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into rem, keep difference if no borrow
    assign w_rem_sh   = {r_acc[AW-1:WIDTH], r_x[WIDTH-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_y});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_y;
    assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // Two's-complement negations used by the sign fix-up
    assign w_prod_neg = ~r_acc + AW'(1);
    assign w_quot_neg = ~r_acc[WIDTH-1:0] + WIDTH'(1);
    assign w_rem_neg  = ~r_acc[AW-1:WIDTH] + WIDTH'(1);

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_is_div  <= 1'b0;
            r_res_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_is_div  <= bus.op[1];
                        r_res_neg <= w_a_neg ^ w_b_neg;
                        r_rem_neg <= w_a_neg;
                        r_x       <= bus.op[1] ? w_a_mag : w_b_mag;
                        r_y       <= bus.op[1] ? w_b_mag : w_a_mag;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_x   <= r_is_div ? {r_x[WIDTH-2:0], 1'b0} : {1'b0, r_x[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= r_rem_neg ? w_rem_neg : r_acc[AW-1:WIDTH];
                        r_lo <= r_res_neg ? w_quot_neg : r_acc[WIDTH-1:0];
                    end else begin
                        {r_hi, r_lo} <= r_res_neg ? w_prod_neg : r_acc;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks for mul_div_unit: results, latency, busy/done window, handshake rules.
module tb_mul_div_unit;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    localparam int         LAT      = 33;   // edges from accepting edge to the edge that raises done

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    mul_div_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the documented divide corner cases
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] qa;
        logic signed [31:0] qb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        logic [63:0]        res;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        case (op)
            OP_MULTU: res = {32'd0, a} * {32'd0, b};
            OP_MULT:  res = sa * sb;
            OP_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 32'd0)
                    res = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {32'h0, 32'h8000_0000};
                else begin
                    q   = qa / qb;
                    r   = qa % qb;
                    res = {r, q};
                end
            end
        endcase
        return res;
    endfunction

    // Present an op at the current negedge, let the next edge accept it, then scramble operands
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Wait for done (bounded); checks busy/done and hi/lo stability on every cycle before it
    task automatic wait_done(input int pulse_at, output int lat);
        int          n;
        bit          bad;
        logic [63:0] held;
        n    = 0;
        bad  = 1'b0;
        held = {bus.hi, bus.lo};
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad = 1'b1;
        while (bus.done !== 1'b1 && n < 60) begin
            if (n == pulse_at) bus.start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            n++;
            if (bus.done !== 1'b1) begin
                if (bus.busy !== 1'b1 || {bus.hi, bus.lo} !== held) bad = 1'b1;
            end else if (bus.busy !== 1'b0) begin
                bad = 1'b1;
            end
        end
        check("busy_window", 64'(bad), 64'd0);
        lat = n;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
        int lat;
        issue(op, a, b);
        wait_done(-1, lat);
        check({tag, "_lat"}, 64'(lat), 64'(LAT));
        check(tag, {bus.hi, bus.lo}, exp);
    endtask

    initial begin
        int          lat;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;

        run("divu_100_7", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});

        // Reset at RUN cycle 10 aborts and clears the previous result
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        check("abort_quiet", 64'({bus.busy, bus.done}), 64'd0);

        run("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run("mult_m7_6",   OP_MULT,  32'hFFFF_FFF9, 32'd6,         64'hFFFF_FFFF_FFFF_FFD6);
        run("mult_min2",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run("div_m100_7",  OP_DIV,   32'hFFFF_FF9C, 32'd7,         64'hFFFF_FFFE_FFFF_FFF2);
        run("div_100_m7",  OP_DIV,   32'd100,       32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2);
        run("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run("divu_by0",    OP_DIVU,  32'd1234,      32'd0,         {32'd1234, 32'hFFFF_FFFF});
        run("div_m5_by0",  OP_DIV,   32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_0000_0001);
        run("div_5_by0",   OP_DIV,   32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF);
        run("multu_small", OP_MULTU, 32'd12345,     32'd678,       64'd8369910);

        // start pulsed during RUN and during FIX is ignored
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(5, lat);
        check("pulse_run_lat", 64'(lat), 64'(LAT));
        check("pulse_run_res", {bus.hi, bus.lo}, {32'd2, 32'd14});
        @(negedge clk);
        check("pulse_run_idle", 64'({bus.busy, bus.done}), 64'd0);
        issue(OP_MULT, 32'hFFFF_FFF9, 32'd6);
        wait_done(32, lat);
        check("pulse_fix_lat", 64'(lat), 64'(LAT));
        check("pulse_fix_res", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        @(negedge clk);
        check("pulse_fix_idle", 64'({bus.busy, bus.done}), 64'd0);

        // Back-to-back: start held in DONE; first result holds until second FIX
        issue(OP_MULT, 32'hFFFF_FFF9, 32'd6);
        wait_done(-1, lat);
        check("b2b_first", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        issue(OP_DIVU, 32'd100, 32'd7);
        check("b2b_busy", 64'({bus.busy, bus.done}), 64'd2);
        check("b2b_hold", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        wait_done(-1, lat);
        check("b2b_lat", 64'(lat), 64'(LAT));
        check("b2b_second", {bus.hi, bus.lo}, {32'd2, 32'd14});

        // Random ops against the reference model
        for (int i = 0; i < 1000; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) rb = 32'd0;
            if ($urandom_range(0, 19) == 0) ra = 32'h8000_0000;
            issue(rop, ra, rb);
            wait_done(-1, lat);
            check("rand_lat", 64'(lat), 64'(LAT));
            check("rand_res", {bus.hi, bus.lo}, model(rop, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
